// File: rtl/instr_fetch.sv
// Instruction fetch stage: two-state FETCH/ISSUE sequencer that requests one word
// from instruction memory, holds it for the decoder, and computes the next PC.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [25:0] jump_target,
  input  logic [31:0] branch_offset,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        o_dbg_state
);

  // Handshake: in FETCH imem_req stays high with imem_addr stable until a cycle
  // with imem_ack=1, in which imem_rdata is taken; in ISSUE valid=1 presents the
  // instruction and it is consumed on the first edge with stall=0.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  state_t      w_state_nx;
  logic [31:0] w_pc_nx;
  logic [31:0] w_instr_nx;
  logic [31:0] w_pc_plus4_nx;
  logic        w_valid_nx;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_branch_pc;

  // Word offset scaled to bytes; the two top bits fall off the end by design.
  assign w_branch_pc = r_pc_plus4 + {branch_offset[29:0], 2'b00};

  always_comb begin
    w_redirect_pc = r_pc_plus4;
    if (jump) begin
      w_redirect_pc = {r_pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch && zero) begin
      w_redirect_pc = w_branch_pc;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_instr_nx    = r_instr;
    w_pc_plus4_nx = r_pc_plus4;
    w_valid_nx    = r_valid;
    case (r_state)
      ST_FETCH: begin
        if (imem_ack) begin
          w_instr_nx    = imem_rdata;
          w_pc_plus4_nx = r_pc + 32'd4;
          w_valid_nx    = 1'b1;
          w_state_nx    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          w_pc_nx    = w_redirect_pc;
          w_valid_nx = 1'b0;
          w_state_nx = ST_FETCH;
        end
      end
      default: begin
        w_state_nx = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_instr    <= w_instr_nx;
      r_pc_plus4 <= w_pc_plus4_nx;
      r_valid    <= w_valid_nx;
    end
  end

  // Memory-side outputs depend only on registered state.
  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign op_code     = r_instr[31:26];
  assign pc_plus4    = r_pc_plus4;
  assign valid       = r_valid;
  assign o_dbg_state = (r_state == ST_ISSUE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: linear step sequence with hand-computed
// expectations, immediate assertions at each comparison, one summary line.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [25:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] instr;
  logic [5:0]  op_code;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        dbg_state;

  // Second instance with a non-zero reset PC for the mid-fetch reset case.
  logic        reset1;
  logic        imem_req1;
  logic [31:0] imem_addr1;
  logic        imem_ack1;
  logic [31:0] imem_rdata1;
  logic        stall1;
  logic [31:0] instr1;
  logic [5:0]  op_code1;
  logic [31:0] pc_plus41;
  logic        valid1;
  logic        dbg_state1;

  int checks;
  int failures;

  instr_fetch #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
    .branch(branch), .zero(zero), .jump_target(jump_target),
    .branch_offset(branch_offset), .instr(instr), .op_code(op_code),
    .pc_plus4(pc_plus4), .valid(valid), .o_dbg_state(dbg_state)
  );

  instr_fetch #(.RESET_PC(32'h00000100)) dut1 (
    .clk(clk), .reset(reset1), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ack(imem_ack1), .imem_rdata(imem_rdata1), .stall(stall1), .jump(1'b0),
    .branch(1'b0), .zero(1'b0), .jump_target(26'h0),
    .branch_offset(32'h0), .instr(instr1), .op_code(op_code1),
    .pc_plus4(pc_plus41), .valid(valid1), .o_dbg_state(dbg_state1)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_redirect(input logic j, input logic b, input logic z,
                              input logic [25:0] tgt, input logic [31:0] off);
    jump = j; branch = b; zero = z; jump_target = tgt; branch_offset = off;
  endtask

  task automatic ack_word(input logic [31:0] word);
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    set_redirect(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    reset1 = 1'b1; imem_ack1 = 1'b0; imem_rdata1 = 32'h0; stall1 = 1'b0;
    imem_rdata = 32'hDEADBEEF; imem_ack = 1'b1;
    step();
    step();
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h0);
    check("rst_state", {31'h0, dbg_state}, 32'h0);
    reset = 1'b0; imem_ack = 1'b0;
    check("post_rst_req", {31'h0, imem_req}, 32'h1);
    check("post_rst_addr", imem_addr, 32'h0);

    // Sequential fetch with immediate ack.
    ack_word(32'h20080005);
    check("seq1_valid", {31'h0, valid}, 32'h1);
    check("seq1_op", {26'h0, op_code}, 32'h08);
    check("seq1_pc4", pc_plus4, 32'h4);
    check("seq1_req", {31'h0, imem_req}, 32'h0);
    step();
    check("seq2_addr", imem_addr, 32'h4);
    check("seq2_valid_low", {31'h0, valid}, 32'h0);
    ack_word(32'h8D090004);
    check("seq2_op", {26'h0, op_code}, 32'h23);
    check("seq2_pc4", pc_plus4, 32'h8);
    check("seq2_instr", instr, 32'h8D090004);

    // Wait states: three cycles without ack.
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", {31'h0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h8);
      check("wait_valid", {31'h0, valid}, 32'h0);
    end
    ack_word(32'h3C01ABCD);
    check("wait_valid_rise", {31'h0, valid}, 32'h1);
    check("wait_instr", instr, 32'h3C01ABCD);
    check("wait_pc4", pc_plus4, 32'hC);

    // Stall in ISSUE with redirect and memory inputs toggling.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_redirect(i[0], ~i[0], 1'b1, 26'h3FFFFFF, 32'h7FFFFFFF);
      imem_ack = 1'b1; imem_rdata = 32'hFFFF0000 + i;
      step();
      check("stall_instr", instr, 32'h3C01ABCD);
      check("stall_pc4", pc_plus4, 32'hC);
      check("stall_valid", {31'h0, valid}, 32'h1);
      check("stall_req", {31'h0, imem_req}, 32'h0);
    end
    imem_ack = 1'b0; stall = 1'b0;
    set_redirect(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    step();
    check("stall_release_addr", imem_addr, 32'hC);
    check("stall_release_valid", {31'h0, valid}, 32'h0);

    // Jump into the 0x0040xxxx region.
    ack_word(32'h0);
    check("pre_jump_pc4", pc_plus4, 32'h10);
    set_redirect(1'b1, 1'b0, 1'b0, 26'h0100003, 32'h0);
    step();
    check("jump1_addr", imem_addr, 32'h0040000C);
    set_redirect(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    ack_word(32'h08000100);
    check("jump2_pc4", pc_plus4, 32'h00400010);
    set_redirect(1'b1, 1'b1, 1'b1, 26'h0000100, 32'h5);
    step();
    check("jump_wins_addr", imem_addr, 32'h00000400);

    // Branch taken / not taken from pc_plus4 = 0x20.
    ack_word(32'h0);
    set_redirect(1'b1, 1'b0, 1'b0, 26'h7, 32'h0);
    step();
    check("to_1c_addr", imem_addr, 32'h1C);
    ack_word(32'h1000FFFE);
    check("br_pc4", pc_plus4, 32'h20);
    set_redirect(1'b0, 1'b1, 1'b1, 26'h0, 32'hFFFFFFFE);
    step();
    check("br_taken_addr", imem_addr, 32'h18);
    ack_word(32'h0);
    set_redirect(1'b1, 1'b0, 1'b0, 26'h7, 32'h0);
    step();
    ack_word(32'h0);
    set_redirect(1'b0, 1'b1, 1'b0, 26'h0, 32'hFFFFFFFE);
    step();
    check("br_not_taken_addr", imem_addr, 32'h20);

    // PC wrap at 0xFFFFFFFC via a backward branch from pc_plus4 = 0x24.
    ack_word(32'h0);
    set_redirect(1'b0, 1'b1, 1'b1, 26'h0, 32'hFFFFFFF6);
    step();
    check("wrap_addr", imem_addr, 32'hFFFFFFFC);
    set_redirect(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    ack_word(32'hAC000000);
    check("wrap_pc4", pc_plus4, 32'h0);
    check("wrap_valid", {31'h0, valid}, 32'h1);

    // Reset while in ISSUE drops the held instruction.
    stall = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0; stall = 1'b0;
    check("rst_issue_valid", {31'h0, valid}, 32'h0);
    check("rst_issue_instr", instr, 32'h0);
    check("rst_issue_addr", imem_addr, 32'h0);
    check("rst_issue_req", {31'h0, imem_req}, 32'h1);

    // Second instance: reset during a wait state, late ack after release.
    reset1 = 1'b0;
    check("d1_reset_addr", imem_addr1, 32'h100);
    imem_ack1 = 1'b1; imem_rdata1 = 32'h20080001;
    step();
    imem_ack1 = 1'b0;
    check("d1_pc4", pc_plus41, 32'h104);
    step();
    check("d1_fetch2_addr", imem_addr1, 32'h104);
    step();
    step();
    reset1 = 1'b1;
    step();
    reset1 = 1'b0;
    check("d1_midrst_valid", {31'h0, valid1}, 32'h0);
    check("d1_midrst_addr", imem_addr1, 32'h100);
    check("d1_midrst_req", {31'h0, imem_req1}, 32'h1);
    imem_ack1 = 1'b1; imem_rdata1 = 32'h11111111;
    step();
    imem_ack1 = 1'b0;
    check("d1_late_ack_valid", {31'h0, valid1}, 32'h1);
    check("d1_late_ack_instr", instr1, 32'h11111111);
    check("d1_late_ack_pc4", pc_plus41, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
